// File: rtl/tx_frame_pkg.sv
// Shared state encoding and default parameters for the modulator frame sequencer.
package tx_frame_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSync,
        StLen,
        StData,
        StEnd
    } state_e;

    localparam int unsigned DefTimesSlow = 16;
    localparam int unsigned DefPreLen    = 8;
    localparam logic [7:0]  DefSyncWord  = 8'hD3;

endpackage

// File: rtl/symbol_clk_div.sv
// Free-running symbol clock divider: 50% duty clk_slow plus single-cycle edge ticks
// that mark the clk_fast cycle in which clk_slow is driven low or high.
module symbol_clk_div
    import tx_frame_pkg::*;
#(
    parameter int unsigned TIMES_SLOW = DefTimesSlow
) (
    input  logic clk_fast,
    input  logic rst,
    output logic clk_slow,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int unsigned Half = TIMES_SLOW / 2;
    localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Half - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            clk_slow_q, clk_slow_d;
    logic            wrap;

    always_comb begin
        wrap       = (cnt_q == CntMax);
        cnt_d      = wrap ? '0 : cnt_q + CntW'(1);
        clk_slow_d = wrap ? ~clk_slow_q : clk_slow_q;
    end

    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            clk_slow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            clk_slow_q <= clk_slow_d;
        end
    end

    assign clk_slow  = clk_slow_q;
    assign fall_tick = wrap && clk_slow_q;
    assign rise_tick = wrap && !clk_slow_q;

endmodule

// File: rtl/tx_frame_ctrl.sv
// Frame sequencer for the BPSK/ASK modulator: preamble, sync word, length byte and
// payload bytes serialised MSB first, one symbol per clk_slow period.
module tx_frame_ctrl
    import tx_frame_pkg::*;
#(
    parameter int unsigned TIMES_SLOW = DefTimesSlow,
    parameter int unsigned PRE_LEN    = DefPreLen,
    parameter logic [7:0]  SYNC_WORD  = DefSyncWord
) (
    input  logic       clk_fast,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       clk_slow,
    output logic       mod_valid,
    output logic       mod_bit,
    output logic       busy,
    output logic       done,
    output logic       err_underrun
);

    localparam logic [7:0] PreLen = 8'(PRE_LEN);

    state_e     state_q, state_d;
    logic       armed_q, armed_d;
    logic [7:0] len_q, len_d;
    logic [7:0] pre_cnt_q, pre_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] fetched_q, fetched_d;
    logic [7:0] sent_q, sent_d;
    logic       mod_valid_q, mod_valid_d;
    logic       mod_bit_q, mod_bit_d;
    logic       err_q, err_d;

    logic       fall_tick, rise_tick, unused_rise_tick;
    logic       xfer, byte_avail;
    logic [7:0] byte_src;

    symbol_clk_div #(
        .TIMES_SLOW(TIMES_SLOW)
    ) u_div (
        .clk_fast (clk_fast),
        .rst      (rst),
        .clk_slow (clk_slow),
        .fall_tick(fall_tick),
        .rise_tick(rise_tick)
    );

    assign unused_rise_tick = rise_tick;

    assign byte_ready = ((state_q == StLen) || (state_q == StData)) && !hold_full_q
                        && (fetched_q < len_q);
    assign xfer       = byte_valid && byte_ready;
    // A byte arriving on the boundary cycle bypasses the holding register.
    assign byte_src   = hold_full_q ? hold_q : byte_in;
    assign byte_avail = hold_full_q || xfer;

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        len_d       = len_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        fetched_d   = fetched_q;
        sent_d      = sent_q;
        mod_valid_d = mod_valid_q;
        mod_bit_d   = mod_bit_q;
        err_d       = 1'b0;

        if (xfer) begin
            hold_d      = byte_in;
            hold_full_d = 1'b1;
            fetched_d   = fetched_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (!armed_q && start) begin
                    armed_d = 1'b1;
                    len_d   = len;
                end else if (armed_q && fall_tick) begin
                    armed_d     = 1'b0;
                    state_d     = StPre;
                    pre_cnt_d   = 8'd1;
                    mod_valid_d = 1'b1;
                    mod_bit_d   = 1'b1;
                    fetched_d   = '0;
                    sent_d      = '0;
                    hold_full_d = 1'b0;
                end
            end
            StPre: begin
                if (fall_tick) begin
                    if (pre_cnt_q == PreLen) begin
                        state_d   = StSync;
                        sh_d      = SYNC_WORD;
                        mod_bit_d = SYNC_WORD[7];
                        bit_cnt_d = '0;
                    end else begin
                        // Even symbol indices carry 1.
                        mod_bit_d = ~pre_cnt_q[0];
                        pre_cnt_d = pre_cnt_q + 8'd1;
                    end
                end
            end
            StSync, StLen, StData: begin
                if (fall_tick) begin
                    if (bit_cnt_q != 3'd7) begin
                        sh_d      = {sh_q[6:0], 1'b0};
                        mod_bit_d = sh_q[6];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (state_q == StSync) begin
                        state_d   = StLen;
                        sh_d      = len_q;
                        mod_bit_d = len_q[7];
                        bit_cnt_d = '0;
                    end else if (sent_q == len_q) begin
                        state_d     = StEnd;
                        mod_valid_d = 1'b0;
                        mod_bit_d   = 1'b0;
                    end else if (byte_avail) begin
                        state_d     = StData;
                        sh_d        = byte_src;
                        mod_bit_d   = byte_src[7];
                        bit_cnt_d   = '0;
                        sent_d      = sent_q + 8'd1;
                        hold_full_d = 1'b0;
                    end else begin
                        state_d     = StIdle;
                        mod_valid_d = 1'b0;
                        mod_bit_d   = 1'b0;
                        err_d       = 1'b1;
                    end
                end
            end
            StEnd: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            len_q       <= '0;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            fetched_q   <= '0;
            sent_q      <= '0;
            mod_valid_q <= 1'b0;
            mod_bit_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            len_q       <= len_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            fetched_q   <= fetched_d;
            sent_q      <= sent_d;
            mod_valid_q <= mod_valid_d;
            mod_bit_q   <= mod_bit_d;
            err_q       <= err_d;
        end
    end

    assign mod_valid    = mod_valid_q;
    assign mod_bit      = mod_bit_q;
    assign busy         = (state_q != StIdle) || armed_q;
    assign done         = (state_q == StEnd);
    assign err_underrun = err_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Self-checking bench for tx_frame_ctrl: symbols seen on clk_slow rises are compared
// against a frame built from the field layout (preamble, sync, length, payload).
module tb_tx_frame_ctrl;

    localparam int unsigned TimesSlow = 16;
    localparam int unsigned PreLen    = 8;
    localparam logic [7:0]  SyncWord  = 8'hD3;
    localparam int          Timeout   = 4000;

    logic       clk_fast = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       clk_slow;
    logic       mod_valid;
    logic       mod_bit;
    logic       busy;
    logic       done;
    logic       err_underrun;

    always #5 clk_fast = ~clk_fast;

    tx_frame_ctrl #(
        .TIMES_SLOW(TimesSlow),
        .PRE_LEN   (PreLen),
        .SYNC_WORD (SyncWord)
    ) dut (
        .clk_fast    (clk_fast),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .clk_slow    (clk_slow),
        .mod_valid   (mod_valid),
        .mod_bit     (mod_bit),
        .busy        (busy),
        .done        (done),
        .err_underrun(err_underrun)
    );

    int checks = 0;
    int errors = 0;

    // Monitor-owned observations (monotonic, never cleared).
    logic bit_q[$];
    int   valid_cycles = 0, done_cycles = 0, err_cycles = 0, ready_cycles = 0;
    int   done_busy = 0, busy_fall_done = 0, err_valid_hi = 0;
    logic prev_slow = 1'b0, prev_done = 1'b0;

    // Snapshots taken by the test sequence.
    int s_bits, s_valid, s_done, s_err, s_ready, s_dbusy, s_dfall, s_errv;

    // Byte source: tests own src_q/src_base, the driver owns src_taken.
    logic [7:0]  src_q[$];
    int          src_base = 0;
    int          src_taken = 0;
    int unsigned valid_pct = 100;
    logic        xfer_pending = 1'b0;
    logic        exp_q[$];

    always @(negedge clk_fast) begin
        if (clk_slow && !prev_slow && mod_valid) bit_q.push_back(mod_bit);
        prev_slow = clk_slow;
        if (mod_valid) valid_cycles++;
        if (byte_ready) ready_cycles++;
        if (prev_done && !busy) busy_fall_done++;
        prev_done = done;
        if (done) begin
            done_cycles++;
            if (busy) done_busy++;
        end
        if (err_underrun) begin
            err_cycles++;
            if (mod_valid) err_valid_hi++;
        end
    end

    initial begin
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        forever begin
            @(negedge clk_fast);
            if (xfer_pending && rst) src_taken++;
            if ((src_taken - src_base) < src_q.size() && $urandom_range(99) < valid_pct) begin
                byte_valid = 1'b1;
                byte_in    = src_q[src_taken - src_base];
            end else begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
            end
            // byte_ready only moves on posedge, so this is what the next edge will see.
            xfer_pending = byte_valid && byte_ready;
        end
    end

    task automatic snap();
        s_bits  = bit_q.size();
        s_valid = valid_cycles;
        s_done  = done_cycles;
        s_err   = err_cycles;
        s_ready = ready_cycles;
        s_dbusy = done_busy;
        s_dfall = busy_fall_done;
        s_errv  = err_valid_hi;
    endtask

    task automatic load_src(input int n);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
        src_base = src_taken;
    endtask

    // Expected symbol stream from the frame layout; only the first nbytes payload bytes.
    task automatic build_exp(input logic [7:0] l, input int nbytes);
        logic [7:0] sw;
        logic [7:0] b;
        sw = SyncWord;
        exp_q.delete();
        for (int i = 0; i < int'(PreLen); i++) exp_q.push_back((i % 2) == 0);
        for (int i = 7; i >= 0; i--) exp_q.push_back(sw[i]);
        for (int i = 7; i >= 0; i--) exp_q.push_back(l[i]);
        for (int k = 0; k < nbytes; k++) begin
            b = src_q[k];
            for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        end
    endtask

    // -1 when the symbols captured since base equal exp_q, -2 on length difference.
    function automatic int frame_diff(input int base);
        if (bit_q.size() - base != exp_q.size()) return -2;
        for (int i = 0; i < exp_q.size(); i++)
            if (bit_q[base + i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic send_start(input logic [7:0] l);
        @(negedge clk_fast);
        start = 1'b1;
        len   = l;
        @(negedge clk_fast);
        start = 1'b0;
        len   = 8'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < Timeout) begin
            @(negedge clk_fast);
            n++;
        end
        repeat (2) @(negedge clk_fast);
        checks++;
        if (n >= Timeout) begin
            errors++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        int n;
        logic seen_low;
        #10;
        checks++;
        if ({clk_slow, mod_valid, mod_bit, busy, done, err_underrun, byte_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {clk_slow, mod_valid, mod_bit, busy, done, err_underrun, byte_ready});
        end
        #8;
        rst = 1'b1;
        n = 0;
        do begin
            @(posedge clk_fast); #1; n++;
        end while (clk_slow !== 1'b1 && n < 40);
        checks++;
        if (n != TimesSlow / 2) begin
            errors++;
            $display("FAIL first_rise: got edge %0d, required %0d", n, TimesSlow / 2);
        end
        n = 0;
        seen_low = 1'b0;
        do begin
            @(posedge clk_fast); #1; n++;
            if (clk_slow === 1'b0) seen_low = 1'b1;
        end while (!(seen_low && clk_slow === 1'b1) && n < 40);
        checks++;
        if (n != TimesSlow) begin
            errors++;
            $display("FAIL slow_period: got %0d cycles, required %0d", n, TimesSlow);
        end
        checks++;
        if ({mod_valid, busy, done, err_underrun} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b, required 0000",
                     {mod_valid, busy, done, err_underrun});
        end
    endtask

    task automatic test_fixed_frame();
        int d;
        valid_pct = 100;
        src_q     = '{8'hA5, 8'h3C};
        src_base  = src_taken;
        build_exp(8'd2, 2);
        snap();
        send_start(8'd2);
        checks++;
        if ({busy, mod_valid} !== 2'b10) begin
            errors++;
            $display("FAIL start_busy: got busy,mod_valid=%b, required 10", {busy, mod_valid});
        end
        wait_idle("fixed");
        d = frame_diff(s_bits);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL fixed_bits: got %0d symbols (diff at %0d), required %0d",
                     bit_q.size() - s_bits, d, exp_q.size());
        end
        checks++;
        if (valid_cycles - s_valid != 640) begin
            errors++;
            $display("FAIL fixed_valid_cycles: got %0d, required 640", valid_cycles - s_valid);
        end
        checks++;
        if (done_cycles - s_done != 1 || err_cycles - s_err != 0) begin
            errors++;
            $display("FAIL fixed_pulses: got done=%0d err=%0d, required done=1 err=0",
                     done_cycles - s_done, err_cycles - s_err);
        end
        checks++;
        if (done_busy - s_dbusy != 1 || busy_fall_done - s_dfall != 1) begin
            errors++;
            $display("FAIL fixed_busy_done: got busy_in_done=%0d fall_after=%0d, required 1 1",
                     done_busy - s_dbusy, busy_fall_done - s_dfall);
        end
    endtask

    task automatic test_len_zero();
        int d;
        load_src(0);
        build_exp(8'd0, 0);
        snap();
        send_start(8'd0);
        wait_idle("len0");
        d = frame_diff(s_bits);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL len0_bits: got %0d symbols (diff at %0d), required %0d",
                     bit_q.size() - s_bits, d, exp_q.size());
        end
        checks++;
        if (ready_cycles - s_ready != 0) begin
            errors++;
            $display("FAIL len0_ready: got %0d ready cycles, required 0", ready_cycles - s_ready);
        end
        checks++;
        if (done_cycles - s_done != 1) begin
            errors++;
            $display("FAIL len0_done: got %0d, required 1", done_cycles - s_done);
        end
    endtask

    task automatic test_random_frames();
        int d;
        int l;
        for (int it = 0; it < 4; it++) begin
            l = int'($urandom_range(5, 1));
            load_src(l);
            valid_pct = $urandom_range(100, 30);
            build_exp(8'(l), l);
            snap();
            send_start(8'(l));
            wait_idle("random");
            d = frame_diff(s_bits);
            checks++;
            if (d != -1) begin
                errors++;
                $display("FAIL random_bits len=%0d: got %0d symbols (diff at %0d), required %0d",
                         l, bit_q.size() - s_bits, d, exp_q.size());
            end
            checks++;
            if (done_cycles - s_done != 1 || err_cycles - s_err != 0 ||
                valid_cycles - s_valid != exp_q.size() * TimesSlow) begin
                errors++;
                $display("FAIL random_status len=%0d: got done=%0d err=%0d valid=%0d, required 1 0 %0d",
                         l, done_cycles - s_done, err_cycles - s_err, valid_cycles - s_valid,
                         exp_q.size() * TimesSlow);
            end
        end
        valid_pct = 100;
    endtask

    task automatic test_underrun();
        int d;
        int l;
        int k;
        for (int it = 0; it < 3; it++) begin
            l = (it == 0) ? 3 : int'($urandom_range(5, 2));
            k = (it == 0) ? 1 : int'($urandom_range(l - 1, 0));
            load_src(k);
            build_exp(8'(l), k);
            snap();
            send_start(8'(l));
            wait_idle("underrun");
            d = frame_diff(s_bits);
            checks++;
            if (d != -1) begin
                errors++;
                $display("FAIL underrun_bits len=%0d k=%0d: got %0d symbols (diff at %0d), required %0d",
                         l, k, bit_q.size() - s_bits, d, exp_q.size());
            end
            checks++;
            if (err_cycles - s_err != 1 || done_cycles - s_done != 0) begin
                errors++;
                $display("FAIL underrun_pulses: got err=%0d done=%0d, required err=1 done=0",
                         err_cycles - s_err, done_cycles - s_done);
            end
            checks++;
            if (err_valid_hi - s_errv != 0 ||
                valid_cycles - s_valid != exp_q.size() * TimesSlow) begin
                errors++;
                $display("FAIL underrun_valid: got valid_at_err=%0d valid=%0d, required 0 %0d",
                         err_valid_hi - s_errv, valid_cycles - s_valid, exp_q.size() * TimesSlow);
            end
        end
    endtask

    task automatic test_start_during_data();
        int d;
        int n = 0;
        load_src(3);
        build_exp(8'd3, 3);
        snap();
        send_start(8'd3);
        while (bit_q.size() - s_bits < 26 && n < Timeout) begin
            @(negedge clk_fast);
            n++;
        end
        checks++;
        if (n >= Timeout) begin
            errors++;
            $display("FAIL busy_start_wait: got %0d symbols, required 26", bit_q.size() - s_bits);
        end
        send_start(8'd7);
        wait_idle("busy_start");
        d = frame_diff(s_bits);
        checks++;
        if (d != -1 || done_cycles - s_done != 1) begin
            errors++;
            $display("FAIL busy_start_frame: got %0d symbols (diff %0d) done=%0d, required %0d done=1",
                     bit_q.size() - s_bits, d, done_cycles - s_done, exp_q.size());
        end
        repeat (40) @(negedge clk_fast);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_rearm: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int d;
        int n = 0;
        load_src(2);
        send_start(8'd2);
        while (!(bit_q.size() >= 10 && clk_slow === 1'b1) && n < Timeout) begin
            @(negedge clk_fast);
            n++;
        end
        @(negedge clk_fast);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({clk_slow, mod_valid, mod_bit, busy, done, err_underrun, byte_ready} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b, required 0000000",
                     {clk_slow, mod_valid, mod_bit, busy, done, err_underrun, byte_ready});
        end
        repeat (3) @(negedge clk_fast);
        rst = 1'b1;
        repeat (2) @(negedge clk_fast);
        load_src(2);
        build_exp(8'd2, 2);
        snap();
        send_start(8'd2);
        wait_idle("post_reset");
        d = frame_diff(s_bits);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL post_reset_bits: got %0d symbols (diff at %0d), required %0d",
                     bit_q.size() - s_bits, d, exp_q.size());
        end
        checks++;
        if (done_cycles - s_done != 1 || err_cycles - s_err != 0) begin
            errors++;
            $display("FAIL post_reset_pulses: got done=%0d err=%0d, required 1 0",
                     done_cycles - s_done, err_cycles - s_err);
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        len   = 8'h00;
        test_reset();
        test_fixed_frame();
        test_len_zero();
        test_random_frames();
        test_underrun();
        test_start_during_data();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
